// File: rtl/command_executor_pkg.sv
// Shared console types: parser command codes, parameter bundle, executor state.
// Also provides the CONSOLE_LINES / CONSOLE_COLUMNS screen geometry macros.
`ifndef CONSOLE_LINES
`define CONSOLE_LINES 24
`endif
`ifndef CONSOLE_COLUMNS
`define CONSOLE_COLUMNS 80
`endif

package command_executor_pkg;

    typedef enum logic [3:0] {
        CMD_NONE, INPUT, IND, NEL, RI, CUU, CUD, CUF, CUB, CUP,
        DECSC, DECRC, ED, EL, SGR
    } CommandsType;

    typedef struct packed {
        logic [7:0] Pn1;
        logic [7:0] Pn2;
        logic [7:0] Pns;
        logic [7:0] Pchar;
    } Param_t;

    typedef enum logic {IDLE, CLEAR} ExecState_t;

    localparam logic [7:0] BLANK = 8'h20;

    // Modular add for operands already below m; avoids a divider.
    function automatic int unsigned wrap_add(int unsigned a, int unsigned b, int unsigned m);
        return (a + b >= m) ? a + b - m : a + b;
    endfunction

endpackage

// File: rtl/command_executor_row_clearer.sv
// Blanks one physical text row: COLS consecutive writes, columns ascending.
module row_clearer
    import command_executor_pkg::*;
#(
    parameter int COLS = 80,
    parameter int ROWS = 24,
    localparam int XW = $clog2(COLS),
    localparam int YW = $clog2(ROWS),
    localparam int AW = $clog2(COLS*ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [YW-1:0] physRow,
    output logic          we,
    output logic [AW-1:0] addr,
    output logic          done
);

    logic [XW-1:0] col;
    logic          active;

    assign we   = active;
    assign done = active && (col == XW'(COLS-1));

    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            col    <= '0;
            addr   <= '0;
        end else if (start) begin
            active <= 1'b1;
            col    <= '0;
            addr   <= AW'(physRow) * AW'(COLS);
        end else if (active) begin
            if (done) begin
                active <= 1'b0;
            end else begin
                col  <= col + XW'(1);
                addr <= addr + AW'(1);
            end
        end
    end

endmodule

// File: rtl/command_executor.sv
// Executes parser commands: cursor motion, character writes and circular scrolling.
// Define AUTOWRAP_EN to wrap to the next line after writing the last column.
`ifndef CONSOLE_LINES
`define CONSOLE_LINES 24
`endif
`ifndef CONSOLE_COLUMNS
`define CONSOLE_COLUMNS 80
`endif

module command_executor
    import command_executor_pkg::*;
#(
    parameter int COLS = `CONSOLE_COLUMNS,
    parameter int ROWS = `CONSOLE_LINES,
    localparam int XW = $clog2(COLS),
    localparam int YW = $clog2(ROWS),
    localparam int AW = $clog2(COLS*ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          commandReady,
    input  CommandsType   commandType,
    input  Param_t        param,
    output logic [XW-1:0] cursorX,
    output logic [YW-1:0] cursorY,
    output logic [YW-1:0] topLine,
    output logic          ramWe,
    output logic [AW-1:0] ramAddr,
    output logic [7:0]    ramData,
    output logic          busy,
    output logic          overflow
);

    localparam logic [XW-1:0] XMAX = XW'(COLS-1);
    localparam logic [YW-1:0] YMAX = YW'(ROWS-1);

    ExecState_t    state;
    logic [XW-1:0] sx;
    logic [YW-1:0] sy;
    logic          pendValid;
    CommandsType   pendCmd;
    Param_t        pendPar;
    logic          chWe;
    logic [AW-1:0] chAddr;
    logic [7:0]    chData;
    logic          deferPend;
    logic [YW-1:0] deferRow;

    logic          exec, wr, lf, rev, scroll, defer;
    CommandsType   ec;
    Param_t        ep;
    logic [XW-1:0] nx, nsx;
    logic [YW-1:0] ny, nsy, ntop, clrRow, physY;
    logic [8:0]    step, sum;
    logic [AW-1:0] wrAddr;

    logic          clrStart, clrWe, clrDone;
    logic [YW-1:0] clrStartRow;
    logic [AW-1:0] clrAddr;
    logic          unused_pns;

    assign unused_pns = ^ep.Pns;

    always_comb begin
        exec   = (state == IDLE) && (pendValid || commandReady);
        ec     = pendValid ? pendCmd : commandType;
        ep     = pendValid ? pendPar : param;
        nx     = cursorX;
        ny     = cursorY;
        nsx    = sx;
        nsy    = sy;
        ntop   = topLine;
        wr     = 1'b0;
        lf     = 1'b0;
        rev    = 1'b0;
        defer  = 1'b0;
        scroll = 1'b0;
        clrRow = topLine;
        sum    = '0;
        step   = (ep.Pn1 == 8'd0) ? 9'd1 : {1'b0, ep.Pn1};
        case (ec)
            INPUT: begin
                if (ep.Pchar >= 8'h20 && ep.Pchar <= 8'h7E) begin
                    wr = 1'b1;
                    if (cursorX != XMAX) nx = cursorX + XW'(1);
`ifdef AUTOWRAP_EN
                    else begin
                        // char write goes first, the clear starts one cycle later
                        nx    = '0;
                        lf    = 1'b1;
                        defer = 1'b1;
                    end
`endif
                end else begin
                    case (ep.Pchar)
                        8'h0D:               nx = '0;
                        8'h0A, 8'h0B, 8'h0C: lf = 1'b1;
                        8'h08:               if (cursorX != '0) nx = cursorX - XW'(1);
                        default: ;
                    endcase
                end
            end
            IND: lf = 1'b1;
            NEL: begin
                nx = '0;
                lf = 1'b1;
            end
            RI:  rev = 1'b1;
            CUU: ny = (step > 9'(cursorY)) ? '0 : YW'(9'(cursorY) - step);
            CUD: begin
                sum = 9'(cursorY) + step;
                ny  = (sum > 9'(ROWS-1)) ? YMAX : YW'(sum);
            end
            CUF: begin
                sum = 9'(cursorX) + step;
                nx  = (sum > 9'(COLS-1)) ? XMAX : XW'(sum);
            end
            CUB: nx = (step > 9'(cursorX)) ? '0 : XW'(9'(cursorX) - step);
            CUP: begin
                ny = (ep.Pn1 == 8'd0) ? '0 :
                     ({1'b0, ep.Pn1} > 9'(ROWS)) ? YMAX : YW'(ep.Pn1 - 8'd1);
                nx = (ep.Pn2 == 8'd0) ? '0 :
                     ({1'b0, ep.Pn2} > 9'(COLS)) ? XMAX : XW'(ep.Pn2 - 8'd1);
            end
            DECSC: begin
                nsx = cursorX;
                nsy = cursorY;
            end
            DECRC: begin
                nx = sx;
                ny = sy;
            end
            default: ;
        endcase

        if (lf) begin
            if (cursorY != YMAX) ny = cursorY + YW'(1);
            else begin
                scroll = 1'b1;
                clrRow = topLine;
                ntop   = YW'(wrap_add(32'(topLine), 32'd1, ROWS));
            end
        end
        if (rev) begin
            if (cursorY != '0) ny = cursorY - YW'(1);
            else begin
                scroll = 1'b1;
                ntop   = YW'(wrap_add(32'(topLine), ROWS - 1, ROWS));
                clrRow = ntop;
            end
        end

        physY  = YW'(wrap_add(32'(topLine), 32'(cursorY), ROWS));
        wrAddr = AW'(physY) * AW'(COLS) + AW'(cursorX);
    end

    assign clrStart    = (exec && scroll && !defer) || deferPend;
    assign clrStartRow = deferPend ? deferRow : clrRow;

    row_clearer #(.COLS(COLS), .ROWS(ROWS)) u_clr (
        .clk     (clk),
        .rst     (rst),
        .start   (clrStart),
        .physRow (clrStartRow),
        .we      (clrWe),
        .addr    (clrAddr),
        .done    (clrDone)
    );

    assign busy    = (state == CLEAR);
    assign ramWe   = chWe | clrWe;
    assign ramAddr = chWe ? chAddr : clrAddr;
    assign ramData = chWe ? chData : (clrWe ? BLANK : 8'h00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cursorX   <= '0;
            cursorY   <= '0;
            topLine   <= '0;
            sx        <= '0;
            sy        <= '0;
            pendValid <= 1'b0;
            pendCmd   <= CMD_NONE;
            pendPar   <= '0;
            overflow  <= 1'b0;
            chWe      <= 1'b0;
            chAddr    <= '0;
            chData    <= '0;
            deferPend <= 1'b0;
            deferRow  <= '0;
        end else begin
            chWe      <= exec && wr;
            chAddr    <= wrAddr;
            chData    <= ep.Pchar;
            deferPend <= exec && scroll && defer;
            deferRow  <= clrRow;

            if (exec) begin
                cursorX <= nx;
                cursorY <= ny;
                topLine <= ntop;
                sx      <= nsx;
                sy      <= nsy;
            end

            // the slot drains in IDLE; an arrival in that same cycle refills it
            if (state == IDLE) begin
                if (pendValid) begin
                    pendValid <= commandReady;
                    if (commandReady) begin
                        pendCmd <= commandType;
                        pendPar <= param;
                    end
                end
            end else if (commandReady) begin
                if (!pendValid) begin
                    pendValid <= 1'b1;
                    pendCmd   <= commandType;
                    pendPar   <= param;
                end else begin
                    overflow <= 1'b1;
                end
            end

            case (state)
                IDLE:    if (exec && scroll) state <= CLEAR;
                CLEAR:   if (clrDone) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_command_executor.sv
// Scoreboarded bench for command_executor against a screen-level reference model.
module tb_command_executor;
    import command_executor_pkg::*;

    localparam int COLS = 80;
    localparam int ROWS = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic        commandReady;
    CommandsType commandType;
    Param_t      param;
    logic [6:0]  cursorX;
    logic [4:0]  cursorY;
    logic [4:0]  topLine;
    logic        ramWe;
    logic [10:0] ramAddr;
    logic [7:0]  ramData;
    logic        busy;
    logic        overflow;

    always #5 clk = ~clk;

    command_executor #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk(clk), .rst(rst), .commandReady(commandReady), .commandType(commandType),
        .param(param), .cursorX(cursorX), .cursorY(cursorY), .topLine(topLine),
        .ramWe(ramWe), .ramAddr(ramAddr), .ramData(ramData), .busy(busy), .overflow(overflow)
    );

    typedef struct { int addr; int data; } wr_t;
    wr_t expq[$];
    wr_t e;
    int  nvec = 0, nerr = 0;
    int  mx, my, mtop, msx, msy, movf;

    task automatic chk(string nm, int act, int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Write monitor: every RAM write must match the next expected one.
    always @(negedge clk) begin
        if (!rst && ramWe) begin
            nvec++;
            if (expq.size() == 0) begin
                nerr++;
                $display("FAIL ram_write: unexpected write addr %0d data %02h", ramAddr, ramData);
            end else begin
                e = expq.pop_front();
                if (int'(ramAddr) != e.addr || int'(ramData) != e.data) begin
                    nerr++;
                    $display("FAIL ram_write: got addr %0d data %02h, expected addr %0d data %02h",
                             ramAddr, ramData, e.addr, e.data);
                end
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic push_clear(int row);
        for (int c = 0; c < COLS; c++) expq.push_back('{row*COLS + c, 32'h20});
    endtask

    task automatic m_lf();
        if (my < ROWS-1) my++;
        else begin
            push_clear(mtop);
            mtop = (mtop + 1) % ROWS;
        end
    endtask

    task automatic m_exec(CommandsType c, Param_t p);
        int n, ch;
        n  = (p.Pn1 == 0) ? 1 : int'(p.Pn1);
        ch = int'(p.Pchar);
        case (c)
            INPUT: begin
                if (ch >= 32 && ch <= 126) begin
                    expq.push_back('{((mtop + my) % ROWS)*COLS + mx, ch});
                    if (mx < COLS-1) mx++;
                    else begin
`ifdef AUTOWRAP_EN
                        mx = 0;
                        m_lf();
`endif
                    end
                end else if (ch == 13) mx = 0;
                else if (ch >= 10 && ch <= 12) m_lf();
                else if (ch == 8) mx = (mx > 0) ? mx - 1 : 0;
            end
            IND: m_lf();
            NEL: begin mx = 0; m_lf(); end
            RI: begin
                if (my > 0) my--;
                else begin
                    mtop = (mtop + ROWS - 1) % ROWS;
                    push_clear(mtop);
                end
            end
            CUU: my = (my - n < 0) ? 0 : my - n;
            CUD: my = (my + n > ROWS-1) ? ROWS-1 : my + n;
            CUF: mx = (mx + n > COLS-1) ? COLS-1 : mx + n;
            CUB: mx = (mx - n < 0) ? 0 : mx - n;
            CUP: begin
                my = (p.Pn1 == 0) ? 0 : (int'(p.Pn1) > ROWS) ? ROWS-1 : int'(p.Pn1) - 1;
                mx = (p.Pn2 == 0) ? 0 : (int'(p.Pn2) > COLS) ? COLS-1 : int'(p.Pn2) - 1;
            end
            DECSC: begin msx = mx; msy = my; end
            DECRC: begin mx = msx; my = msy; end
            default: ;
        endcase
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic Param_t mkp(int a, int b, int ch);
        Param_t p;
        p.Pn1   = 8'(a);
        p.Pn2   = 8'(b);
        p.Pns   = 8'($urandom_range(0, 255));
        p.Pchar = 8'(ch);
        return p;
    endfunction

    task automatic send(CommandsType c, Param_t p);
        @(posedge clk); #1;
        commandReady = 1'b1;
        commandType  = c;
        param        = p;
        @(posedge clk); #1;
        commandReady = 1'b0;
    endtask

    task automatic issue(CommandsType c, Param_t p);
        m_exec(c, p);
        send(c, p);
    endtask

    task automatic settle();
        int q = 0, n = 0;
        while (q < 4 && n < 1000) begin
            @(posedge clk); #1;
            n++;
            if (busy || ramWe) q = 0; else q++;
        end
        if (q < 4) chk("settle_timeout", n, 0);
    endtask

    task automatic chk_state(string tag);
        chk({tag, "_cursorX"}, cursorX, mx);
        chk({tag, "_cursorY"}, cursorY, my);
        chk({tag, "_topLine"}, topLine, mtop);
        chk({tag, "_overflow"}, overflow, movf);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        commandReady = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mx = 0; my = 0; mtop = 0; msx = 0; msy = 0; movf = 0;
        expq.delete();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int b, r;
        CommandsType c;
        commandType = CMD_NONE;
        param = '0;
        do_reset();

        chk("rst_cursorX", cursorX, 0);
        chk("rst_cursorY", cursorY, 0);
        chk("rst_topLine", topLine, 0);
        chk("rst_ramWe", ramWe, 0);
        chk("rst_ramAddr", ramAddr, 0);
        chk("rst_ramData", ramData, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);

        // single character: one write the cycle after the strobe
        issue(INPUT, mkp(0, 0, 8'h41));
        chk("char_we_latency", ramWe, 1);
        @(posedge clk); #1;
        chk("char_we_one_cycle", ramWe, 0);
        settle();
        chk_state("charA");
        chk("charA_x_const", cursorX, 1);

        issue(CUP, mkp(5, 10, 0));   settle(); chk_state("cup5_10");
        chk("cup5_10_xy", {cursorX, 1'b0, cursorY}, {7'd9, 1'b0, 5'd4});
        issue(CUP, mkp(0, 200, 0));  settle(); chk_state("cup0_200");
        chk("cup0_200_xy", {cursorX, 1'b0, cursorY}, {7'd79, 1'b0, 5'd0});

        // bottom-line linefeed scrolls and blanks the old top row
        issue(CUP, mkp(24, 1, 0)); settle();
        issue(INPUT, mkp(0, 0, 8'h0A));
        chk("lf_busy_rise", busy, 1);
        chk("lf_topLine", topLine, 1);
        b = 0;
        while (busy && b < 200) begin b++; @(posedge clk); #1; end
        chk("lf_busy_cycles", b, COLS);
        settle(); chk_state("lf_bottom");

        // back-to-back scrolls at COLS+2 spacing, then a held and a dropped command
        issue(IND, mkp(0, 0, 0));
        repeat (COLS) @(posedge clk);
        issue(IND, mkp(0, 0, 0));
        repeat (10) @(posedge clk);
        issue(INPUT, mkp(0, 0, 8'h42));
        chk("pending_no_overflow", overflow, 0);
        repeat (5) @(posedge clk);
        send(CUF, mkp(3, 0, 0));
        movf = 1;
        settle(); chk_state("pending");

        // reverse index at the top
        do_reset();
        issue(RI, mkp(0, 0, 0)); settle(); chk_state("ri_top");
        chk("ri_topLine_const", topLine, 23);

        // save/restore and clamped moves
        issue(CUP, mkp(3, 7, 0)); issue(DECSC, mkp(0, 0, 0));
        issue(CUP, mkp(10, 10, 0)); issue(DECRC, mkp(0, 0, 0)); settle(); chk_state("decrc");
        issue(CUU, mkp(0, 0, 0)); issue(CUB, mkp(200, 0, 0)); settle(); chk_state("clamp_lo");
        issue(CUF, mkp(255, 0, 0)); issue(CUD, mkp(255, 0, 0)); settle(); chk_state("clamp_hi");

        // 81 printable characters from the home position
        do_reset();
        for (int i = 0; i < 81; i++) issue(INPUT, mkp(0, 0, $urandom_range(32, 126)));
        settle(); chk_state("wrap81");
`ifdef AUTOWRAP_EN
        chk("wrap81_xy", {cursorX, 1'b0, cursorY}, {7'd1, 1'b0, 5'd1});
`else
        chk("wrap81_xy", {cursorX, 1'b0, cursorY}, {7'd79, 1'b0, 5'd0});
`endif

        // randomized command stream
        do_reset();
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 19);
            case (r)
                0,1,2,3,4,5,6,7: c = INPUT;
                8, 9: c = IND;
                10: c = NEL;
                11: c = RI;
                12: c = CUU;
                13: c = CUD;
                14: c = CUF;
                15: c = CUB;
                16: c = CUP;
                17: c = DECSC;
                18: c = DECRC;
                default: c = CommandsType'(4'($urandom_range(11, 14)));
            endcase
            r = $urandom_range(0, 9);
            if (r < 6) r = $urandom_range(32, 126);
            else if (r < 8) r = ($urandom_range(0, 4) == 0) ? 8 : $urandom_range(10, 13);
            else r = $urandom_range(0, 255);
            if ($urandom_range(0, 5) != 0)
                issue(c, mkp($urandom_range(0, 30), $urandom_range(0, 90), r));
            else
                issue(c, mkp($urandom_range(0, 255), $urandom_range(0, 255), r));
            if ($urandom_range(0, 3) == 0 || busy) begin
                settle();
                chk_state("rand");
            end
        end
        settle();
        chk_state("rand_end");
        chk("queue_empty", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/command_executor.md
# command_executor

Consumes the one-cycle command pulses from the escape-sequence parser and executes cursor and text commands: tracks the cursor, writes printable characters into the text RAM and scrolls the screen. Scrolling moves a circular top-line pointer and blanks the row that becomes visible, so no RAM copy is needed. Sits between the parser and the text-buffer RAM/renderer.

## Interface
- `COLS`, default 80: columns per line.
- `ROWS`, default `` `CONSOLE_LINES `` (24): lines per screen.
- `clk` in 1: system clock.
- `rst` in 1: reset.
- `commandReady` in 1: one-cycle command strobe from the parser.
- `commandType` in `CommandsType`: command code, valid while `commandReady` is high.
- `param` in `Param_t`: Pn1/Pn2/Pns/Pchar fields, valid while `commandReady` is high.
- `cursorX` out $clog2(COLS): cursor column, 0-based.
- `cursorY` out $clog2(ROWS): logical cursor row, 0-based.
- `topLine` out $clog2(ROWS): physical RAM row shown as logical row 0.
- `ramWe` out 1: text RAM write strobe.
- `ramAddr` out $clog2(COLS*ROWS): write address, physRow*COLS + col.
- `ramData` out 8: write data.
- `busy` out 1: a row clear is in progress.
- `overflow` out 1: sticky; a command was dropped.
- One clock; reset is synchronous and active-high. Ports are `clk` and `rst`.

## Operation
- State machine states:
  - IDLE to CLEAR when a command needs a scroll.
  - CLEAR to IDLE after the COLS-th write.
- Physical row = topLine + row, minus ROWS if the sum is ≥ ROWS. No divider.
- INPUT with Pchar 0x20–0x7E:
  - Writes Pchar at (cursorX, cursorY), then X+1.
  - At X = COLS-1 the wrap behaviour is set by the macro (see Configuration).
- INPUT control characters:
  - 0x0D: X←0.
  - 0x0A, 0x0B, 0x0C: linefeed.
  - 0x08: X←max(X-1,0).
  - All other codes below 0x20, and 0x7F, are ignored.
- Linefeed and IND: if Y<ROWS-1 then Y+1; else topLine←(topLine+1) mod ROWS and clear the old top physical row.
- NEL: X←0, then linefeed.
- RI: if Y>0 then Y-1; else topLine←(topLine-1) mod ROWS and clear the new top physical row.
- CUU, CUD, CUF, CUB:
  - Step n = max(Pn1,1).
  - Result clamps to 0..ROWS-1 (Y) or 0..COLS-1 (X).
  - Compute in 9 bits before clamping; no wrap.
- CUP: Y←clamp(Pn1,1,ROWS)-1 and X←clamp(Pn2,1,COLS)-1. A value of 0 is treated as 1.
- DECSC saves (X,Y). DECRC restores it. The saved pair resets to (0,0).
- All other command types are consumed without effect.
- Row clear: writes 0x20 to columns 0..COLS-1 of the target physical row, one write per cycle.
- Single-entry pending slot:
  - A command arriving while CLEAR is active is held in the slot.
  - A further arrival while the slot is full is dropped and sets `overflow`.

## Timing
- Reset values: every output is 0, the pending slot is empty and the saved position is (0,0). Text RAM contents are not cleared.
- Reset during CLEAR aborts the clear. A partially blanked row is acceptable.
- A command in IDLE is accepted on its `commandReady` cycle. Cursor and topLine update at the next edge.
- Character write: `ramWe` is high for exactly one cycle, the cycle after `commandReady`. Address and data are registered with it.
- Scroll timing:
  - topLine updates and `busy` rises the cycle after the command.
  - Then COLS consecutive `ramWe` cycles follow, columns ascending.
  - `busy` drops in the cycle after the last write.
- The pending command executes in the first IDLE cycle.
- If a new `commandReady` arrives in that same cycle, the pending command executes and the new one takes the slot.
- Worst-case input rate is one command every COLS+2 cycles without loss.

## Configuration
- `AUTOWRAP_EN` defined: after a write at X=COLS-1, X←0 and a linefeed follows, which may scroll.
- `AUTOWRAP_EN` undefined: X stays at COLS-1, and later characters overwrite the last column.

## Structure
- Shared package `DataType.svh`:
  - Existing `CommandsType` and `Param_t`, plus `` `CONSOLE_LINES ``.
  - Add `` `CONSOLE_COLUMNS `` (80) and the state enum `ExecState_t` {IDLE, CLEAR}.
- Sub-module `row_clearer`: column counter plus address generator. Its interface is start, physRow, done and the write strobe/address.

## Test plan
- Reset, then INPUT 'A' (0x41): one `ramWe`, ramAddr=0, ramData=0x41, then cursorX=1.
- CUP Pn1=5, Pn2=10: (X,Y)=(9,4). CUP Pn1=0, Pn2=200: (X,Y)=(79,0).
- CUP Pn1=24, then LF: topLine=1, `busy` high for 80 cycles, writes 0x20 to addresses 0..79, cursorY stays 23.
- LF at the bottom, then INPUT 'B' during the clear: 'B' is written after `busy` falls, at address ((1+23) mod 24)*80+X = X. A third command during the clear sets `overflow`.
- With topLine=0, RI at Y=0: topLine=23 and row 23 (addresses 1840..1919) is cleared.
- `AUTOWRAP_EN` defined vs undefined: 81 printable characters from (0,0) end at (1,1) vs (79,0).
